// File: rtl/nucleotide_keypad_if.sv
// Button/output bundle for the nucleotide keypad conditioner.
// slave = conditioner side, master = board/bench side driving raw buttons.
interface nucleotide_keypad_if;
    logic       A;
    logic       G;
    logic       C;
    logic       T;
    logic       A_debounced;
    logic       G_debounced;
    logic       C_debounced;
    logic       T_debounced;
    logic       A_pressed;
    logic       G_pressed;
    logic       C_pressed;
    logic       T_pressed;
    logic       sym_valid;
    logic [1:0] sym;
    logic       collide;

    modport slave (
        input  A, G, C, T,
        output A_debounced, G_debounced, C_debounced, T_debounced,
        output A_pressed, G_pressed, C_pressed, T_pressed,
        output sym_valid, sym, collide
    );

    modport master (
        output A, G, C, T,
        input  A_debounced, G_debounced, C_debounced, T_debounced,
        input  A_pressed, G_pressed, C_pressed, T_pressed,
        input  sym_valid, sym, collide
    );
endinterface

// File: rtl/nucleotide_keypad.sv
// Four-channel A/G/C/T button conditioner: 2-FF synchroniser, consecutive-
// sample debounce, rising-edge press pulse and a registered symbol encoder.
// Channel index doubles as the symbol code: 0=A, 1=G, 2=C, 3=T.
module nucleotide_keypad #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              reset,
    nucleotide_keypad_if.slave kp
);

    logic [3:0]       raw;
    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       stable;
    logic [3:0]       pulse;
    logic [CNT_W-1:0] cnt [4];

    logic             one_hot;
    logic             multi;
    logic [1:0]       code;

    logic             sym_valid_q;
    logic             collide_q;
    logic [1:0]       sym_q;

    assign raw = {kp.T, kp.C, kp.G, kp.A};

    // Synchronise, debounce and detect accepted rising edges on every channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            pulse  <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            pulse <= '0;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    // Level held long enough: accept it; only 0->1 makes a pulse.
                    stable[i] <= s2[i];
                    pulse[i]  <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Classify the pulse vector: single press, collision, or nothing.
    always_comb begin
        one_hot = (pulse != 4'd0) && ((pulse & (pulse - 4'd1)) == 4'd0);
        multi   = (pulse != 4'd0) && !one_hot;
        code    = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (pulse[i]) begin
                code = 2'(i);
            end
        end
    end

    // Register the encoder strobes; sym holds its last valid code.
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_valid_q <= 1'b0;
            collide_q   <= 1'b0;
            sym_q       <= 2'b00;
        end else begin
            sym_valid_q <= one_hot;
            collide_q   <= multi;
            if (one_hot) begin
                sym_q <= code;
            end
        end
    end

    assign kp.A_debounced = stable[0];
    assign kp.G_debounced = stable[1];
    assign kp.C_debounced = stable[2];
    assign kp.T_debounced = stable[3];
    assign kp.A_pressed   = pulse[0];
    assign kp.G_pressed   = pulse[1];
    assign kp.C_pressed   = pulse[2];
    assign kp.T_pressed   = pulse[3];
    assign kp.sym_valid   = sym_valid_q;
    assign kp.collide     = collide_q;
    assign kp.sym         = sym_q;

endmodule

// File: doc/nucleotide_keypad.md
# nucleotide_keypad

Four-channel input conditioner for the A/G/C/T push-buttons of the mutation-detector lab. Each raw button is synchronised, debounced by a consecutive-sample counter and converted to a one-cycle press pulse. A registered symbol encoder then presents one nucleotide per press to the downstream sequence-detector FSM, which consumes the debounced levels, the pulses, or the encoded symbol.

## Interface
- DEBOUNCE_CYCLES, default 4: consecutive cycles of a changed synchronised level needed to accept it (≥2); board builds override, e.g. 500000.
- CNT_W, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- clk  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- A, G, C, T  in  1 each  raw asynchronous button levels, active-high.
- A_debounced, G_debounced, C_debounced, T_debounced  out  1 each  accepted stable level.
- A_pressed, G_pressed, C_pressed, T_pressed  out  1 each  one-cycle pulse on accepted rising edge.
- sym_valid  out  1  one-cycle strobe: exactly one press accepted in the previous cycle.
- sym  out  2  code A=00, G=01, C=10, T=11; valid only with sym_valid, else held.
- collide  out  1  one-cycle strobe: two or more presses accepted in the same cycle.

## Operation
- Per channel: 2-FF synchroniser (s1, s2), stable register, CNT_W counter, pulse register; all four channels identical and independent.
- Counter: if s2 == stable, counter <= 0. Else if counter == DEBOUNCE_CYCLES-1, stable <= s2 and counter <= 0. Otherwise counter increments.
- A single sample of s2 == stable restarts the count; a glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Pulse register <= 1 exactly on the edge where stable goes 0→1, else 0. A release (1→0) produces no pulse.
- *_debounced = stable register; *_pressed = pulse register. Both are registered outputs with no combinational path from the inputs.
- Encoder, registered from the four pulse registers:
  - exactly one pulse: sym_valid <= 1 and sym <= its code;
  - two or more: collide <= 1, sym_valid <= 0, sym unchanged;
  - none: both strobes 0.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

## Timing
- Reset: s1, s2, stable, counters, pulses, sym_valid, collide all 0; sym = 00. Effective on the first edge with reset high.
- Reset mid-debounce discards the partial count.
- A button held through reset is seen as a new press after release. Its pulse occurs DEBOUNCE_CYCLES+1 edges after the first edge with reset low.
- Press latency, with raw high and stable before edge k:
  - s1 = 1 after edge k, s2 = 1 after edge k+1;
  - stable and *_pressed = 1 after edge k+1+DEBOUNCE_CYCLES;
  - *_pressed falls after edge k+2+DEBOUNCE_CYCLES;
  - sym_valid/collide = 1 after edge k+2+DEBOUNCE_CYCLES, for one cycle.
- Release latency is symmetric: stable falls after edge k+1+DEBOUNCE_CYCLES, with no pulse and no strobe.
- Held button: exactly one pulse per accepted press, regardless of hold length.
- Back-to-back presses on different channels in consecutive cycles give consecutive sym_valid strobes, with no loss.

## Test plan
- Reset values: assert reset 3 cycles with A..T = 1 → all outputs 0, sym = 00. Deassert → A..T_pressed each pulse once, 5 edges later (N=4); collide = 1 one cycle after; sym_valid stays 0.
- Clean press, N=4: G rises before edge 10, held 20 cycles → G_debounced = 1 after edge 15; G_pressed high only in cycle after edge 15; sym_valid = 1 with sym = 01 in cycle after edge 16.
- Bounce rejection: T toggles 1,0,1,1,1,0,… with runs ≤3 cycles → T_debounced stays 0, no pulse, no strobe. A following clean 4-cycle run → exactly one pulse, sym = 11.
- Release: C held, then dropped → C_debounced falls 5 edges after drop; C_pressed, sym_valid and collide all stay 0.
- Collision vs sequence: A and C rise the same cycle → collide = 1 once, sym_valid = 0. A then C one cycle apart → sym_valid two consecutive cycles, sym 00 then 10.
- Reset mid-debounce: A rises, reset asserted 2 edges later for 1 cycle, A kept high → no pulse before reset; one pulse 5 edges after first post-reset edge.
